lock_timer_ctrl: RTL and testbench
==================================

Name: lock_timer_ctrl

Overview:
- Chamber (lock) sequencer that acts as the initiator on the countdown-timer interface.
- Issues timer start pulses with a duration in seconds, then consumes the timer's level "done" signal.
- Runs fill (low->high) and drain (high->low) operations; each is a transfer phase followed by a hold/dwell phase.
- Sits between user request inputs and one shared countdown timer instance.

Parameters:
- SEC_W, 10: width of the duration field; max duration 2^SEC_W-1 seconds.
- FILL_SECS, 300: fill phase duration (5 min).
- DRAIN_SECS, 420: drain phase duration (7 min).
- HOLD_SECS, 480: post-transfer dwell duration (8 min).

Ports:
- clk  in  1  system clock; timer_done is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- fill_req  in  1  request fill; level, sampled in IDLE only.
- drain_req  in  1  request drain; level, sampled in IDLE only.
- abort  in  1  cancel current operation.
- timer_done  in  1  timer level output; 1 when its count is zero.
- timer_start  out  1  one-cycle pulse; timer loads timer_seconds.
- timer_seconds  out  SEC_W  duration for the timer; registered, held stable between starts.
- level  out  1  chamber level: 0 = low, 1 = high.
- busy  out  1  high in every state except IDLE.
- filling  out  1  high in FILL_ARM/FILL_WAIT.
- draining  out  1  high in DRAIN_ARM/DRAIN_WAIT.
- holding  out  1  high in HOLD_ARM/HOLD_WAIT.
- phase_done  out  1  one-cycle pulse when a fill or drain transfer completes.
- req_err  out  1  one-cycle pulse when a request is invalid for the current level.

Behaviour:
- Reset: state=IDLE; level=0; timer_start=0; timer_seconds=0; phase_done=0; req_err=0. Status outputs follow state (all 0). Reset overrides every other input, including mid-operation.
- All outputs are registered; status outputs are decoded from the state register.
- States: IDLE, FILL_START, FILL_ARM, FILL_WAIT, DRAIN_START, DRAIN_ARM, DRAIN_WAIT, HOLD_START, HOLD_ARM, HOLD_WAIT.
- IDLE request handling:
  - fill_req and level=0 -> FILL_START.
  - drain_req and level=1 -> DRAIN_START.
  - Both requests high: the one valid for the current level wins; no req_err.
  - Single request invalid for the level -> req_err pulse next cycle; stay IDLE.
- X_START states (1 cycle each):
  - timer_start=1; timer_seconds = FILL_SECS, DRAIN_SECS or HOLD_SECS respectively.
  - Next state is the matching X_ARM.
- X_ARM (1 cycle): timer_done is ignored, because the timer reloads on the start edge. Next state is X_WAIT.
- FILL_WAIT / DRAIN_WAIT:
  - First sampled timer_done=1 -> level <= 1 (fill) or 0 (drain) on that edge.
  - phase_done pulses in the following cycle; state -> HOLD_START.
- HOLD_WAIT: timer_done=1 -> IDLE. No pulse; level unchanged.
- Latency from request in IDLE at cycle T:
  - timer_start high in T+1; ARM in T+2; done first sampled in T+3.
  - A zero-duration phase (parameter=0) completes at T+3.
- Abort:
  - In any non-IDLE state: -> IDLE next edge; level unchanged; no phase_done.
  - No timer_start is issued; the timer is left as is, and the next start reloads it.
  - Abort in IDLE is ignored.
  - Abort and timer_done in the same WAIT cycle: abort wins, so level does not change.
- Requests outside IDLE are ignored silently; no req_err and no queuing.
- timer_seconds holds its last value after a phase until the next X_START.

Test Plan:
- Bench timer model decrements once per clk; FILL/DRAIN/HOLD = 5/7/8.
- Reset, then fill_req in IDLE at T0 -> timer_start in T1 with timer_seconds=5, filling T2..; level=1 and phase_done pulse 1 cycle after done; hold start with 8; busy drops after hold done.
- level=1, drain_req -> timer_seconds=7, draining asserted, level=0 at done, then 8 s hold, return to IDLE.
- level=0, drain_req alone -> req_err single pulse, busy stays 0, no timer_start; both fill_req and drain_req high -> fill starts, no req_err.
- Abort during FILL_WAIT with 3 counts left -> IDLE next cycle, level stays 0, no phase_done; a subsequent fill_req restarts with timer_seconds=5.
- Abort asserted in the same cycle as timer_done in DRAIN_WAIT -> level remains 1; reset asserted during HOLD_WAIT -> all outputs at reset values next cycle, level=0.
- FILL_SECS=0 -> done already high during the ARM cycle is ignored; completion sampled at T+3; phase_done one cycle later.

Source files
------------

// File: rtl/lock_timer_ctrl_if.sv
// lock_timer_ctrl_if: countdown-timer link between the lock sequencer and a shared timer
//   timer_start   - one-cycle pulse from the initiator; timer loads timer_seconds
//   timer_seconds - duration in seconds, held stable between starts
//   timer_done    - timer level output, 1 while its count is zero
//   modports: master (sequencer side), slave (timer side)
interface lock_timer_ctrl_if #(parameter int SEC_W = 10);
   logic             timer_start;
   logic [SEC_W-1:0] timer_seconds;
   logic             timer_done;
   modport master (output timer_start, timer_seconds, input timer_done);
   modport slave  (input timer_start, timer_seconds, output timer_done);
endinterface

// File: rtl/lock_timer_ctrl.sv
// lock_timer_ctrl: chamber fill/drain sequencer driving one shared countdown timer
//   clk          - system clock
//   reset        - synchronous active-high reset
//   i_fill_req   - fill request (level, sampled in IDLE)
//   i_drain_req  - drain request (level, sampled in IDLE)
//   i_abort      - cancel the current operation
//   tmr          - timer link (master): start pulse, duration, done level
//   o_level      - chamber level, 0 = low, 1 = high
//   o_busy       - any state other than IDLE
//   o_filling    - fill transfer armed/waiting
//   o_draining   - drain transfer armed/waiting
//   o_holding    - post-transfer dwell armed/waiting
//   o_phase_done - one-cycle pulse when a transfer completes
//   o_req_err    - one-cycle pulse for a request invalid at the current level
module lock_timer_ctrl #(
   parameter int SEC_W      = 10,
   parameter int FILL_SECS  = 300,
   parameter int DRAIN_SECS = 420,
   parameter int HOLD_SECS  = 480
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_fill_req,
   input  logic                    i_drain_req,
   input  logic                    i_abort,
   lock_timer_ctrl_if.master       tmr,
   output logic                    o_level,
   output logic                    o_busy,
   output logic                    o_filling,
   output logic                    o_draining,
   output logic                    o_holding,
   output logic                    o_phase_done,
   output logic                    o_req_err
);
   typedef enum logic [3:0] {
      IDLE, FILL_START, FILL_ARM, FILL_WAIT, DRAIN_START, DRAIN_ARM, DRAIN_WAIT,
      HOLD_START, HOLD_ARM, HOLD_WAIT
   } state_t;

   state_t           r_state, w_next;
   logic             r_level, r_phase_done, r_req_err, w_req_err;
   logic [SEC_W-1:0] r_seconds;

   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;

   // ARM states exist so a stale done from before the reload is never sampled
   always_comb begin
      w_next    = r_state;
      w_req_err = 1'b0;
      case (r_state)
         IDLE:
            if (i_fill_req && !r_level)      w_next = FILL_START;
            else if (i_drain_req && r_level) w_next = DRAIN_START;
            else                             w_req_err = i_fill_req | i_drain_req;
         FILL_START:  w_next = FILL_ARM;
         FILL_ARM:    w_next = FILL_WAIT;
         FILL_WAIT:   w_next = tmr.timer_done ? HOLD_START : FILL_WAIT;
         DRAIN_START: w_next = DRAIN_ARM;
         DRAIN_ARM:   w_next = DRAIN_WAIT;
         DRAIN_WAIT:  w_next = tmr.timer_done ? HOLD_START : DRAIN_WAIT;
         HOLD_START:  w_next = HOLD_ARM;
         HOLD_ARM:    w_next = HOLD_WAIT;
         HOLD_WAIT:   w_next = tmr.timer_done ? IDLE : HOLD_WAIT;
         default:     w_next = IDLE;
      endcase
      // abort beats a simultaneous done, so the level never changes on abort
      if (i_abort && r_state != IDLE) w_next = IDLE;
   end

   always_comb begin
      o_busy          = r_state != IDLE;
      o_filling       = r_state == FILL_ARM  || r_state == FILL_WAIT;
      o_draining      = r_state == DRAIN_ARM || r_state == DRAIN_WAIT;
      o_holding       = r_state == HOLD_ARM  || r_state == HOLD_WAIT;
      tmr.timer_start = r_state == FILL_START || r_state == DRAIN_START || r_state == HOLD_START;
   end

   always_ff @(posedge clk)
      if (reset) begin
         r_level      <= 1'b0;
         r_seconds    <= '0;
         r_phase_done <= 1'b0;
         r_req_err    <= 1'b0;
      end else begin
         r_req_err    <= w_req_err;
         r_phase_done <= (r_state == FILL_WAIT || r_state == DRAIN_WAIT) && w_next == HOLD_START;
         r_level      <= (r_state == FILL_WAIT  && w_next == HOLD_START) ? 1'b1 :
                         (r_state == DRAIN_WAIT && w_next == HOLD_START) ? 1'b0 : r_level;
         r_seconds    <= w_next == FILL_START  ? SEC_W'(FILL_SECS)  :
                         w_next == DRAIN_START ? SEC_W'(DRAIN_SECS) :
                         w_next == HOLD_START  ? SEC_W'(HOLD_SECS)  : r_seconds;
      end

   assign tmr.timer_seconds = r_seconds;
   assign o_level           = r_level;
   assign o_phase_done      = r_phase_done;
   assign o_req_err         = r_req_err;
endmodule

// File: tb/tb_lock_timer_ctrl.sv
// tb_lock_timer_ctrl: directed bench for lock_timer_ctrl with a per-clock countdown timer model
module tb_lock_timer_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic fill_req = 1'b0, drain_req = 1'b0, abort = 1'b0;
   logic level, busy, filling, draining, holding, phase_done, req_err;
   logic z_fill = 1'b0;
   logic z_level, z_busy, z_filling, z_draining, z_holding, z_phase_done, z_req_err;
   logic [9:0] t_cnt, z_cnt;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   lock_timer_ctrl_if #(.SEC_W(10)) tif ();
   lock_timer_ctrl_if #(.SEC_W(10)) zif ();

   lock_timer_ctrl #(.SEC_W(10), .FILL_SECS(5), .DRAIN_SECS(7), .HOLD_SECS(8)) dut (
      .clk(clk), .reset(reset), .i_fill_req(fill_req), .i_drain_req(drain_req), .i_abort(abort),
      .tmr(tif.master), .o_level(level), .o_busy(busy), .o_filling(filling), .o_draining(draining),
      .o_holding(holding), .o_phase_done(phase_done), .o_req_err(req_err));

   lock_timer_ctrl #(.SEC_W(10), .FILL_SECS(0), .DRAIN_SECS(7), .HOLD_SECS(8)) zdut (
      .clk(clk), .reset(reset), .i_fill_req(z_fill), .i_drain_req(1'b0), .i_abort(1'b0),
      .tmr(zif.master), .o_level(z_level), .o_busy(z_busy), .o_filling(z_filling), .o_draining(z_draining),
      .o_holding(z_holding), .o_phase_done(z_phase_done), .o_req_err(z_req_err));

   always @(posedge clk)
      if (reset) t_cnt <= '0;
      else if (tif.timer_start) t_cnt <= tif.timer_seconds;
      else if (t_cnt != 0) t_cnt <= t_cnt - 1'b1;
   assign tif.timer_done = t_cnt == 0;

   always @(posedge clk)
      if (reset) z_cnt <= '0;
      else if (zif.timer_start) z_cnt <= zif.timer_seconds;
      else if (z_cnt != 0) z_cnt <= z_cnt - 1'b1;
   assign zif.timer_done = z_cnt == 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (level !== 1'b0) begin errors++; $display("FAIL rst_level got=%0b want=0", level); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b want=0", busy); end
      checks++; if (tif.timer_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%0b want=0", tif.timer_start); end
      checks++; if (tif.timer_seconds !== 10'd0) begin errors++; $display("FAIL rst_seconds got=%0d want=0", tif.timer_seconds); end
      checks++; if ({phase_done, req_err, filling, draining, holding} !== 5'b0) begin errors++; $display("FAIL rst_status got=%b want=00000", {phase_done, req_err, filling, draining, holding}); end
      checks++; if (z_level !== 1'b0) begin errors++; $display("FAIL rst_zlevel got=%0b want=0", z_level); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      fill_req = 1'b1;
      tick();
      checks++; if (tif.timer_start !== 1'b1) begin errors++; $display("FAIL fill_start got=%0b want=1", tif.timer_start); end
      checks++; if (tif.timer_seconds !== 10'd5) begin errors++; $display("FAIL fill_secs got=%0d want=5", tif.timer_seconds); end
      checks++; if (busy !== 1'b1 || filling !== 1'b0) begin errors++; $display("FAIL fill_t1_status busy=%0b filling=%0b want 1/0", busy, filling); end
      fill_req = 1'b0;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      checks++; if (filling !== 1'b1 || tif.timer_start !== 1'b0) begin errors++; $display("FAIL fill_arm filling=%0b start=%0b want 1/0", filling, tif.timer_start); end
      checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL fill_busy_req_err got=%0b want=0", req_err); end
      repeat (5) tick();
      checks++; if (level !== 1'b0 || phase_done !== 1'b0) begin errors++; $display("FAIL fill_pre_done level=%0b pd=%0b want 0/0", level, phase_done); end
      tick();
      checks++; if (level !== 1'b1 || phase_done !== 1'b1) begin errors++; $display("FAIL fill_done level=%0b pd=%0b want 1/1", level, phase_done); end
      checks++; if (tif.timer_start !== 1'b1 || tif.timer_seconds !== 10'd8) begin errors++; $display("FAIL hold_start start=%0b secs=%0d want 1/8", tif.timer_start, tif.timer_seconds); end
      tick();
      checks++; if (holding !== 1'b1 || phase_done !== 1'b0) begin errors++; $display("FAIL hold_arm holding=%0b pd=%0b want 1/0", holding, phase_done); end
      repeat (8) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_last busy=%0b want=1", busy); end
      tick();
      checks++; if (busy !== 1'b0 || level !== 1'b1 || tif.timer_seconds !== 10'd8) begin errors++; $display("FAIL fill_idle busy=%0b level=%0b secs=%0d want 0/1/8", busy, level, tif.timer_seconds); end
   endtask

   task automatic test_drain();
      drain_req = 1'b1;
      tick();
      checks++; if (tif.timer_start !== 1'b1 || tif.timer_seconds !== 10'd7) begin errors++; $display("FAIL drain_start start=%0b secs=%0d want 1/7", tif.timer_start, tif.timer_seconds); end
      drain_req = 1'b0;
      tick();
      checks++; if (draining !== 1'b1) begin errors++; $display("FAIL drain_arm draining=%0b want=1", draining); end
      repeat (7) tick();
      checks++; if (level !== 1'b1 || draining !== 1'b1) begin errors++; $display("FAIL drain_pre_done level=%0b draining=%0b want 1/1", level, draining); end
      tick();
      checks++; if (level !== 1'b0 || phase_done !== 1'b1 || tif.timer_seconds !== 10'd8) begin errors++; $display("FAIL drain_done level=%0b pd=%0b secs=%0d want 0/1/8", level, phase_done, tif.timer_seconds); end
      repeat (9) tick();
      checks++; if (busy !== 1'b1 || holding !== 1'b1) begin errors++; $display("FAIL drain_hold busy=%0b holding=%0b want 1/1", busy, holding); end
      tick();
      checks++; if (busy !== 1'b0 || level !== 1'b0) begin errors++; $display("FAIL drain_idle busy=%0b level=%0b want 0/0", busy, level); end
   endtask

   task automatic test_req_err();
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      checks++; if (req_err !== 1'b1 || busy !== 1'b0 || tif.timer_start !== 1'b0) begin errors++; $display("FAIL req_err_pulse err=%0b busy=%0b start=%0b want 1/0/0", req_err, busy, tif.timer_start); end
      tick();
      checks++; if (req_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL req_err_single err=%0b busy=%0b want 0/0", req_err, busy); end
   endtask

   task automatic test_both_abort_fill();
      fill_req = 1'b1;
      drain_req = 1'b1;
      tick();
      fill_req = 1'b0;
      drain_req = 1'b0;
      checks++; if (tif.timer_start !== 1'b1 || tif.timer_seconds !== 10'd5 || req_err !== 1'b0) begin errors++; $display("FAIL both_req start=%0b secs=%0d err=%0b want 1/5/0", tif.timer_start, tif.timer_seconds, req_err); end
      repeat (3) tick();
      checks++; if (filling !== 1'b1) begin errors++; $display("FAIL abort_fill_pre filling=%0b want=1", filling); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || level !== 1'b0 || phase_done !== 1'b0) begin errors++; $display("FAIL abort_fill busy=%0b level=%0b pd=%0b want 0/0/0", busy, level, phase_done); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (phase_done !== 1'b0 || level !== 1'b0 || tif.timer_start !== 1'b0) begin errors++; $display("FAIL abort_fill_quiet[%0d] pd=%0b level=%0b start=%0b want 0/0/0", i, phase_done, level, tif.timer_start); end
      end
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      checks++; if (tif.timer_start !== 1'b1 || tif.timer_seconds !== 10'd5) begin errors++; $display("FAIL refill_start start=%0b secs=%0d want 1/5", tif.timer_start, tif.timer_seconds); end
      repeat (7) tick();
      checks++; if (level !== 1'b1 || phase_done !== 1'b1) begin errors++; $display("FAIL refill_done level=%0b pd=%0b want 1/1", level, phase_done); end
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || level !== 1'b1) begin errors++; $display("FAIL abort_hold busy=%0b level=%0b want 0/1", busy, level); end
   endtask

   task automatic test_abort_with_done();
      drain_req = 1'b1;
      abort = 1'b1;
      tick();
      drain_req = 1'b0;
      abort = 1'b0;
      checks++; if (tif.timer_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL idle_abort_ignored start=%0b busy=%0b want 1/1", tif.timer_start, busy); end
      repeat (8) tick();
      checks++; if (draining !== 1'b1 || tif.timer_done !== 1'b1) begin errors++; $display("FAIL abort_done_pre draining=%0b done=%0b want 1/1", draining, tif.timer_done); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || level !== 1'b1 || phase_done !== 1'b0) begin errors++; $display("FAIL abort_done busy=%0b level=%0b pd=%0b want 0/1/0", busy, level, phase_done); end
      tick();
      checks++; if (phase_done !== 1'b0 || level !== 1'b1) begin errors++; $display("FAIL abort_done_after pd=%0b level=%0b want 0/1", phase_done, level); end
   endtask

   task automatic test_reset_hold();
      int n = 0;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++; if (busy !== 1'b0 || level !== 1'b0) begin errors++; $display("FAIL prep_drain busy=%0b level=%0b want 0/0 after %0d cycles", busy, level, n); end
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      repeat (9) tick();
      checks++; if (holding !== 1'b1 || level !== 1'b1) begin errors++; $display("FAIL prep_hold holding=%0b level=%0b want 1/1", holding, level); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (level !== 1'b0 || busy !== 1'b0 || holding !== 1'b0) begin errors++; $display("FAIL reset_hold level=%0b busy=%0b holding=%0b want 0/0/0", level, busy, holding); end
      checks++; if (tif.timer_start !== 1'b0 || tif.timer_seconds !== 10'd0 || phase_done !== 1'b0) begin errors++; $display("FAIL reset_hold_tmr start=%0b secs=%0d pd=%0b want 0/0/0", tif.timer_start, tif.timer_seconds, phase_done); end
      tick();
   endtask

   task automatic test_zero();
      z_fill = 1'b1;
      tick();
      z_fill = 1'b0;
      checks++; if (zif.timer_start !== 1'b1 || zif.timer_seconds !== 10'd0) begin errors++; $display("FAIL zero_start start=%0b secs=%0d want 1/0", zif.timer_start, zif.timer_seconds); end
      tick();
      checks++; if (z_filling !== 1'b1 || z_level !== 1'b0) begin errors++; $display("FAIL zero_arm filling=%0b level=%0b want 1/0", z_filling, z_level); end
      tick();
      checks++; if (z_level !== 1'b0 || z_phase_done !== 1'b0) begin errors++; $display("FAIL zero_wait level=%0b pd=%0b want 0/0", z_level, z_phase_done); end
      tick();
      checks++; if (z_level !== 1'b1 || z_phase_done !== 1'b1) begin errors++; $display("FAIL zero_done level=%0b pd=%0b want 1/1", z_level, z_phase_done); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_req_err();
      test_both_abort_fill();
      test_abort_with_done();
      test_reset_hold();
      test_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
